// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: control-word layout, opcode/func encodings, stage states
// and the combinational instruction decoder.
package decode_stage_pkg;

    localparam int unsigned CNTRL_REG_SIZE = 10;

    localparam int unsigned C_ALUINB = 0;
    localparam int unsigned C_ALUOP  = 1;
    localparam int unsigned C_BR     = 2;
    localparam int unsigned C_JP     = 3;
    localparam int unsigned C_JR     = 4;
    localparam int unsigned C_DMWE   = 5;
    localparam int unsigned C_RWE    = 6;
    localparam int unsigned C_RDST   = 7;
    localparam int unsigned C_RWD    = 8;
    localparam int unsigned C_LINK   = 9;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_DIVU = 6'b011011;

    typedef enum logic {StIssue, StBubble} state_e;

    typedef struct packed {
        logic [CNTRL_REG_SIZE-1:0] ctrl;
        logic                      illegal;
        logic                      reads_rt;
    } dec_t;

    // Instruction bit 0 is the MSB, so insn[0:5] (opcode) is word[31:26] here.
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] word);
        return word[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] word);
        return word[20:16];
    endfunction

    function automatic dec_t decode_insn(input logic [31:0] word);
        dec_t       d;
        logic [5:0] fn;
        d  = '0;
        fn = word[5:0];
        case (opcode_of(word))
            OP_RTYPE: begin
                d.reads_rt = 1'b1;
                if (fn inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                               6'b000111, 6'b010000, 6'b010001, 6'b010010, 6'b010011,
                               6'b011000, 6'b011001, 6'b100000, 6'b100001, 6'b100010,
                               6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                               6'b101010, 6'b101011, FN_JR, FN_JALR, FN_DIV, FN_DIVU}) begin
                    d.ctrl[C_RWE]  = 1'b1;
                    d.ctrl[C_RDST] = 1'b1;
                    if (fn == FN_JR || fn == FN_JALR) begin
                        d.ctrl[C_JP] = 1'b1;
                        d.ctrl[C_JR] = 1'b1;
                    end
                    if (fn == FN_JR || fn == FN_DIV || fn == FN_DIVU) d.ctrl[C_RWE] = 1'b0;
                    if (fn == FN_JALR) d.ctrl[C_LINK] = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI, OP_LUI: begin
                d.ctrl[C_ALUINB] = 1'b1;
                d.ctrl[C_RWE]    = 1'b1;
            end
            OP_LW: begin
                d.ctrl[C_ALUINB] = 1'b1;
                d.ctrl[C_RWE]    = 1'b1;
                d.ctrl[C_RWD]    = 1'b1;
            end
            OP_SW: begin
                d.ctrl[C_ALUINB] = 1'b1;
                d.ctrl[C_DMWE]   = 1'b1;
                d.reads_rt       = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.ctrl[C_ALUOP] = 1'b1;
                d.ctrl[C_BR]    = 1'b1;
                d.reads_rt      = 1'b1;
            end
            OP_REGIMM, OP_BLEZ, OP_BGTZ: begin
                d.ctrl[C_ALUOP] = 1'b1;
                d.ctrl[C_BR]    = 1'b1;
            end
            OP_J: d.ctrl[C_JP] = 1'b1;
            OP_JAL: begin
                d.ctrl[C_JP]   = 1'b1;
                d.ctrl[C_RWE]  = 1'b1;
                d.ctrl[C_LINK] = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// General register file: two combinational read ports, one write port, r0 hardwired
// to zero, and same-cycle write-to-read bypass.
module regfile_2r1w #(
    parameter int unsigned NREGS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ra_addr,
    input  logic [4:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [NREGS];
    logic [31:0] mem_d [NREGS];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[waddr] = wdata;
    end

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        if (ra_addr != 5'd0) ra_data = (wr_en && waddr == ra_addr) ? wdata : mem_q[ra_addr];
        if (rb_addr != 5'd0) rb_data = (wr_en && waddr == rb_addr) ? wdata : mem_q[rb_addr];
    end

    always_ff @(posedge clock) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: reads operands, decodes the control word and registers everything for
// execute; inserts a single bubble on a load-use dependency while holding fetch.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               insn_in,
    input  logic                      wb_we,
    input  logic [4:0]                wb_addr,
    input  logic [31:0]               wb_data,
    output logic                      stall,
    output logic                      out_valid,
    output logic [31:0]               pc,
    output logic [31:0]               rs,
    output logic [31:0]               rt,
    output logic [31:0]               insn,
    output logic [CNTRL_REG_SIZE-1:0] control,
    output logic                      illegal
);

    state_e                    state_q, state_d;
    logic                      out_valid_q, out_valid_d;
    logic [31:0]               pc_q, pc_d;
    logic [31:0]               rs_q, rs_d;
    logic [31:0]               rt_q, rt_d;
    logic [31:0]               insn_q, insn_d;
    logic [CNTRL_REG_SIZE-1:0] control_q, control_d;
    logic                      illegal_q, illegal_d;

    logic [31:0] rs_rd, rt_rd;
    logic [4:0]  ld_rt;
    logic        load_use;
    dec_t        dec;

    regfile_2r1w #(
        .NREGS(NREGS)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .ra_addr(rs_of(insn_in)),
        .rb_addr(rt_of(insn_in)),
        .ra_data(rs_rd),
        .rb_data(rt_rd),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    assign dec   = decode_insn(insn_in);
    assign ld_rt = rt_of(insn_q);

    // Only the instruction now in execute can be a load whose result is not ready.
    assign load_use = (state_q == StIssue) && out_valid_q && (opcode_of(insn_q) == OP_LW)
                   && in_valid && (ld_rt != 5'd0)
                   && ((ld_rt == rs_of(insn_in)) || (ld_rt == rt_of(insn_in) && dec.reads_rt));

    always_comb begin
        state_d     = StIssue;
        stall       = 1'b0;
        out_valid_d = 1'b0;
        pc_d        = RESET_PC;
        rs_d        = '0;
        rt_d        = '0;
        insn_d      = '0;
        control_d   = '0;
        illegal_d   = 1'b0;
        if (load_use) begin
            stall   = 1'b1;
            state_d = StBubble;
        end else if (in_valid) begin
            out_valid_d = 1'b1;
            pc_d        = pc_in;
            rs_d        = rs_rd;
            rt_d        = rt_rd;
            insn_d      = insn_in;
            control_d   = dec.ctrl;
            illegal_d   = dec.illegal;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIssue;
            out_valid_q <= 1'b0;
            pc_q        <= RESET_PC;
            rs_q        <= '0;
            rt_q        <= '0;
            insn_q      <= '0;
            control_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            insn_q      <= insn_d;
            control_q   <= control_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign insn      = insn_q;
    assign control   = control_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, bypass, load-use bubble, decode and streaming.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc_in;
    logic [31:0] insn_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        out_valid;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] insn;
    logic [9:0]  control;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    localparam logic [9:0] K_ADDU  = 10'h0C0;
    localparam logic [9:0] K_ADDIU = 10'h041;
    localparam logic [9:0] K_LW    = 10'h141;
    localparam logic [9:0] K_SW    = 10'h021;
    localparam logic [9:0] K_BEQ   = 10'h006;
    localparam logic [9:0] K_JAL   = 10'h248;
    localparam logic [9:0] K_JR    = 10'h098;

    decode_stage dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .pc_in    (pc_in),
        .insn_in  (insn_in),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .stall    (stall),
        .out_valid(out_valid),
        .pc       (pc),
        .rs       (rs),
        .rt       (rt),
        .insn     (insn),
        .control  (control),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'b000000, s, t, d, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0;
        pc_in    = '0;
        insn_in  = '0;
        wb_we    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] w);
        in_valid = 1'b1;
        pc_in    = a;
        insn_in  = w;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        issue(32'h40, rtype(5, 5, 3, 6'b100001));
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        step();
        checks++; if (rs !== 32'h0000_1234) begin failures++; $display("FAIL pre_reset_rs got=%0h exp=%0h", rs, 32'h1234); end
        reset = 1'b1;
        wb_data = 32'h0000_9999;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (control !== 10'h000) begin failures++; $display("FAIL reset_control got=%0h exp=0", control); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        checks++; if (insn !== 32'h0 || rs !== 32'h0 || rt !== 32'h0) begin failures++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0/0/0", insn, rs, rt); end
        checks++; if (illegal !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", illegal, stall); end
        reset = 1'b0;
        idle();
        issue(32'h44, rtype(5, 5, 3, 6'b100001));
        step();
        checks++; if (rs !== 32'h0 || rt !== 32'h0) begin failures++; $display("FAIL reset_r5_cleared got=%0h/%0h exp=0/0", rs, rt); end
        checks++; if (out_valid !== 1'b1 || pc !== 32'h44) begin failures++; $display("FAIL post_reset_issue got=%0b/%0h exp=1/44", out_valid, pc); end
    endtask

    task automatic test_bypass;
        idle();
        issue(32'h50, rtype(5, 5, 3, 6'b100001));
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        checks++; if (rs !== 32'hDEAD_BEEF || rt !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_rs_rt got=%0h/%0h exp=deadbeef", rs, rt); end
        checks++; if (control !== K_ADDU) begin failures++; $display("FAIL addu_control got=%0h exp=%0h", control, K_ADDU); end
        wb_we = 1'b0;
        issue(32'h54, rtype(5, 0, 3, 6'b100001));
        step();
        checks++; if (rs !== 32'hDEAD_BEEF || rt !== 32'h0) begin failures++; $display("FAIL committed_read got=%0h/%0h exp=deadbeef/0", rs, rt); end
        issue(32'h58, rtype(0, 0, 3, 6'b100001));
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h5555_5555;
        step();
        checks++; if (rs !== 32'h0 || rt !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%0h/%0h exp=0/0", rs, rt); end
        wb_we = 1'b0;
        step();
        checks++; if (rs !== 32'h0) begin failures++; $display("FAIL r0_write_ignored got=%0h exp=0", rs); end
    endtask

    task automatic test_load_use;
        logic [31:0] addu_w;
        addu_w = rtype(4, 2, 6, 6'b100001);
        idle();
        issue(32'h60, itype(6'b100011, 1, 4, 16'h0));
        step();
        checks++; if (control !== K_LW || out_valid !== 1'b1) begin failures++; $display("FAIL lw_issue got=%0h/%0b exp=%0h/1", control, out_valid, K_LW); end
        issue(32'h64, addu_w);
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hCAFE_0004;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%0b exp=1", stall); end
        step();
        wb_we = 1'b0;
        checks++; if (out_valid !== 1'b0 || control !== 10'h0 || insn !== 32'h0 || pc !== 32'h0) begin failures++; $display("FAIL bubble got=%0b/%0h/%0h/%0h exp=0/0/0/0", out_valid, control, insn, pc); end
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_one_cycle got=%0b exp=0", stall); end
        step();
        checks++; if (out_valid !== 1'b1 || insn !== addu_w || pc !== 32'h64) begin failures++; $display("FAIL after_bubble got=%0b/%0h/%0h exp=1/%0h/64", out_valid, insn, pc, addu_w); end
        checks++; if (control !== K_ADDU) begin failures++; $display("FAIL after_bubble_ctrl got=%0h exp=%0h", control, K_ADDU); end
        checks++; if (rs !== 32'hCAFE_0004) begin failures++; $display("FAIL stall_writeback got=%0h exp=cafe0004", rs); end
    endtask

    task automatic test_no_false_stall;
        idle();
        issue(32'h70, itype(6'b100011, 1, 4, 16'h0));
        step();
        issue(32'h74, itype(6'b001001, 8, 4, 16'h1));
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL addiu_rt_not_source got=%0b exp=0", stall); end
        step();
        checks++; if (out_valid !== 1'b1 || control !== K_ADDIU || pc !== 32'h74) begin failures++; $display("FAIL addiu_issue got=%0b/%0h/%0h exp=1/%0h/74", out_valid, control, pc, K_ADDIU); end
        issue(32'h78, itype(6'b100011, 1, 4, 16'h0));
        step();
        issue(32'h7C, itype(6'b101011, 9, 4, 16'h8));
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sw_rt_source_stall got=%0b exp=1", stall); end
        step();
        step();
        checks++; if (out_valid !== 1'b1 || control !== K_SW || pc !== 32'h7C) begin failures++; $display("FAIL sw_after_bubble got=%0b/%0h/%0h exp=1/%0h/7c", out_valid, control, pc, K_SW); end
    endtask

    task automatic test_decode;
        idle();
        issue(32'h80, itype(6'b000100, 1, 2, 16'h10));
        step();
        checks++; if (control !== K_BEQ || illegal !== 1'b0) begin failures++; $display("FAIL beq_decode got=%0h/%0b exp=%0h/0", control, illegal, K_BEQ); end
        issue(32'h84, {6'b000011, 26'h10});
        step();
        checks++; if (control !== K_JAL) begin failures++; $display("FAIL jal_decode got=%0h exp=%0h", control, K_JAL); end
        issue(32'h88, itype(6'b101011, 3, 5, 16'h4));
        step();
        checks++; if (control !== K_SW) begin failures++; $display("FAIL sw_decode got=%0h exp=%0h", control, K_SW); end
        issue(32'h8C, 32'hFC00_0000);
        step();
        checks++; if (illegal !== 1'b1 || control !== 10'h0 || out_valid !== 1'b1) begin failures++; $display("FAIL illegal_opcode got=%0b/%0h/%0b exp=1/0/1", illegal, control, out_valid); end
        issue(32'h90, itype(6'b001001, 0, 1, 16'h1));
        step();
        checks++; if (illegal !== 1'b0 || control !== K_ADDIU) begin failures++; $display("FAIL illegal_one_cycle got=%0b/%0h exp=0/%0h", illegal, control, K_ADDIU); end
        issue(32'h94, rtype(1, 2, 3, 6'b111111));
        step();
        checks++; if (illegal !== 1'b1 || control !== 10'h0) begin failures++; $display("FAIL illegal_func got=%0b/%0h exp=1/0", illegal, control); end
        issue(32'h98, rtype(31, 0, 0, 6'b001000));
        step();
        checks++; if (control !== K_JR || illegal !== 1'b0) begin failures++; $display("FAIL jr_decode got=%0h/%0b exp=%0h/0", control, illegal, K_JR); end
    endtask

    task automatic test_back_to_back;
        int valid_run;
        int stalls;
        int pc_errs;
        valid_run = 0;
        stalls    = 0;
        pc_errs   = 0;
        idle();
        for (int i = 0; i < 8; i++) begin
            issue(32'h200 + 32'(i) * 4, itype(6'b001001, 0, 5'(i + 1), 16'(i)));
            #1;
            if (stall !== 1'b0) stalls++;
            step();
            if (out_valid === 1'b1) valid_run++;
            if (pc !== 32'h200 + 32'(i) * 4) pc_errs++;
        end
        checks++; if (valid_run != 8) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=8", valid_run); end
        checks++; if (pc_errs != 0) begin failures++; $display("FAIL b2b_pc_sequence got=%0d exp=0 errors", pc_errs); end
        checks++; if (stalls != 0) begin failures++; $display("FAIL b2b_no_stall got=%0d exp=0", stalls); end
        idle();
        step();
        checks++; if (out_valid !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL idle_bubble got=%0b/%0h exp=0/0", out_valid, pc); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_bypass();
        test_load_use();
        test_no_false_stall();
        test_decode();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
